// File: rtl/mux4_pkg.sv
// Shared select-code definitions for the 4:1 ALU result selector.
package mux4_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_A = 2'b00;
    localparam sel_t SEL_B = 2'b01;
    localparam sel_t SEL_C = 2'b10;
    localparam sel_t SEL_D = 2'b11;

endpackage

// File: rtl/mux2_stage.sv
// N-bit 2:1 multiplexer used as one node of the 4:1 selection tree.
module mux2_stage #(
    parameter int N = 32
) (
    input  logic         s,
    input  logic [N-1:0] i0,
    input  logic [N-1:0] i1,
    output logic [N-1:0] o
);

    assign o = s ? i1 : i0;

endmodule

// File: rtl/mux4_sel.sv
// N-bit 4:1 ALU result selector with combinational y and registered y_q/sel_q.
// Optional MUX4_PARITY_EN adds y_q_par, the XOR reduction of the loaded y_q.
module mux4_sel
    import mux4_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [1:0]   sel,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] c,
    input  logic [N-1:0] d,
    output logic [N-1:0] y,
    output logic [N-1:0] y_q,
    output logic [1:0]   sel_q
`ifdef MUX4_PARITY_EN
    ,
    output logic         y_q_par
`endif
);

    sel_t         sel_c;
    logic [N-1:0] ab_p0;
    logic [N-1:0] cd_p0;

    assign sel_c = sel_t'(sel);

    // First level picks within each pair on sel[0]; second level picks the pair on sel[1].
    mux2_stage #(.N(N)) u_ab (.s(sel_c[0]), .i0(a),     .i1(b),     .o(ab_p0));
    mux2_stage #(.N(N)) u_cd (.s(sel_c[0]), .i0(c),     .i1(d),     .o(cd_p0));
    mux2_stage #(.N(N)) u_y  (.s(sel_c[1]), .i0(ab_p0), .i1(cd_p0), .o(y));

    // Registered copy of the selection
    always_ff @(posedge clk) begin
        if (reset) begin
            y_q   <= '0;
            sel_q <= SEL_A;
        end else if (en) begin
            y_q   <= y;
            sel_q <= sel_c;
        end
    end

`ifdef MUX4_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            y_q_par <= 1'b0;
        end else if (en) begin
            y_q_par <= ^y;
        end
    end
`endif

endmodule

// File: tb/tb_mux4_sel.sv
// Self-checking bench for mux4_sel: vector table for the combinational path,
// scoreboard queue for the registered outputs (parity checked when MUX4_PARITY_EN).
module tb_mux4_sel;

    localparam int N = 32;

    logic         clk;
    logic         reset;
    logic         en;
    logic [1:0]   sel;
    logic [N-1:0] a, b, c, d;
    logic [N-1:0] y;
    logic [N-1:0] y_q;
    logic [1:0]   sel_q;
`ifdef MUX4_PARITY_EN
    logic         y_q_par;
`endif

    mux4_sel #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .sel   (sel),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .y     (y),
        .y_q   (y_q),
        .sel_q (sel_q)
`ifdef MUX4_PARITY_EN
        ,
        .y_q_par (y_q_par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   sel;
        logic [N-1:0] a, b, c, d;
        logic [N-1:0] exp_y;
    } vec_t;

    typedef struct {
        logic [N-1:0] yq;
        logic [1:0]   selq;
        logic         par;
    } exp_t;

    vec_t   vecs[8];
    exp_t   sb[$];
    int     errors = 0;
    int     checks = 0;

    // Bench-side reference state for the registered outputs
    logic [N-1:0] m_yq   = '0;
    logic [1:0]   m_selq = 2'b00;
    logic         m_par  = 1'b0;

    function automatic logic [N-1:0] ref_mux(input logic [1:0] s,
                                             input logic [N-1:0] ia, ib, ic, id);
        case (s)
            2'b00:   return ia;
            2'b01:   return ib;
            2'b10:   return ic;
            default: return id;
        endcase
    endfunction

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle, push the expected register state, then compare after the edge.
    task automatic step(input logic r, input logic e, input logic [1:0] s);
        exp_t x;
        reset = r;
        en    = e;
        sel   = s;
        #1;
        if (r) begin
            m_yq = '0; m_selq = 2'b00; m_par = 1'b0;
        end else if (e) begin
            m_yq   = ref_mux(s, a, b, c, d);
            m_selq = s;
            m_par  = ^m_yq;
        end
        x.yq = m_yq; x.selq = m_selq; x.par = m_par;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check("y_q", y_q, x.yq);
        check("sel_q", {{(N-2){1'b0}}, sel_q}, {{(N-2){1'b0}}, x.selq});
`ifdef MUX4_PARITY_EN
        check("y_q_par", {{(N-1){1'b0}}, y_q_par}, {{(N-1){1'b0}}, x.par});
`endif
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; sel = 2'b00;
        a = 32'h0000_00F0; b = 32'h0000_0FF0; c = 32'h0000_1234; d = 32'h0000_0001;

        vecs[0] = '{2'b00, 32'h0000_00F0, 32'h0000_0FF0, 32'h0000_1234, 32'h1, 32'h0000_00F0};
        vecs[1] = '{2'b01, 32'h0000_00F0, 32'h0000_0FF0, 32'h0000_1234, 32'h1, 32'h0000_0FF0};
        vecs[2] = '{2'b10, 32'h0000_00F0, 32'h0000_0FF0, 32'h0000_1234, 32'h1, 32'h0000_1234};
        vecs[3] = '{2'b11, 32'h0000_00F0, 32'h0000_0FF0, 32'h0000_1234, 32'h1, 32'h0000_0001};
        vecs[4] = '{2'b00, 32'hFFFF_FFFF, 32'h0, 32'hA5A5_5A5A, 32'h8000_0000, 32'hFFFF_FFFF};
        vecs[5] = '{2'b01, 32'hFFFF_FFFF, 32'h0, 32'hA5A5_5A5A, 32'h8000_0000, 32'h0000_0000};
        vecs[6] = '{2'b10, 32'hFFFF_FFFF, 32'h0, 32'hA5A5_5A5A, 32'h8000_0000, 32'hA5A5_5A5A};
        vecs[7] = '{2'b11, 32'hFFFF_FFFF, 32'h0, 32'hA5A5_5A5A, 32'h8000_0000, 32'h8000_0000};

        // Combinational sweep, no clock edge between drive and sample
        #1;
        for (int i = 0; i < 8; i++) begin
            sel = vecs[i].sel; a = vecs[i].a; b = vecs[i].b; c = vecs[i].c; d = vecs[i].d;
            #1;
            check($sformatf("y_vec%0d", i), y, vecs[i].exp_y);
        end

        a = 32'h0000_00F0; b = 32'h0000_0FF0; c = 32'h0000_1234; d = 32'h0000_0001;

        // Reset held two edges with en=1, sel=10; y stays live
        step(1'b1, 1'b1, 2'b10);
        check("y_in_reset0", y, 32'h0000_1234);
        step(1'b1, 1'b1, 2'b10);
        check("y_in_reset1", y, 32'h0000_1234);
        check("y_q_reset_const", y_q, 32'h0);

        // Load then hold
        step(1'b0, 1'b1, 2'b11);
        check("y_q_load_d", y_q, 32'h1);
        step(1'b0, 1'b0, 2'b00);
        check("y_q_hold", y_q, 32'h1);
        check("y_hold_comb", y, 32'h0000_00F0);

        // Reset beats enable
        step(1'b1, 1'b1, 2'b01);
        check("y_q_rst_wins", y_q, 32'h0);

        // Lw-style address through c
        c = 32'h0000_0034; sel = 2'b10; reset = 1'b0; en = 1'b1;
        #1;
        check("y_lw_comb", y, 32'h34);
        step(1'b0, 1'b1, 2'b10);
        check("y_q_lw", y_q, 32'h34);

`ifdef MUX4_PARITY_EN
        a = 32'h0000_0007;
        step(1'b0, 1'b1, 2'b00);
        check("par_7", {31'b0, y_q_par}, 32'h1);
        a = 32'h0000_0003;
        step(1'b0, 1'b1, 2'b00);
        check("par_3", {31'b0, y_q_par}, 32'h0);
        a = 32'h0000_0007;
        step(1'b0, 1'b1, 2'b00);
        step(1'b1, 1'b0, 2'b00);
        check("par_reset", {31'b0, y_q_par}, 32'h0);
`endif

        // Random stream through the scoreboard
        for (int i = 0; i < 40; i++) begin
            logic [1:0] s;
            a = $urandom; b = $urandom; c = $urandom; d = $urandom;
            s = 2'($urandom_range(0, 3));
            sel = s;
            #1;
            check("y_rand", y, ref_mux(s, a, b, c, d));
            step(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), s);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
